// File: rtl/sd_cmd_pkg.sv
// Shared encodings for the SD command physical engine: FSM states, response types, widths.
package sd_cmd_pkg;

  localparam int SHORT_RESP_W = 48;
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_LOAD_COMMAND  = 3'd1,
    ST_SEND_COMMAND  = 3'd2,
    ST_WAIT_RESPONSE = 3'd3,
    ST_WAIT_BUSY     = 3'd4,
    ST_SEND_RESPONSE = 3'd5,
    ST_WAIT_ACK      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE       = 2'd0,
    RESP_SHORT      = 2'd1,
    RESP_LONG       = 2'd2,
    RESP_SHORT_BUSY = 2'd3
  } resp_type_t;

endpackage

// File: rtl/sd_cmd_timeout_counter.sv
// Saturating wait counter with synchronous clear and terminal-count flag; one-cycle update.
// count_next is exported so the caller can register outputs that track the counter.
module sd_cmd_timeout_counter
  import sd_cmd_pkg::*;
#(
  parameter int TERMINAL = 63
) (
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_next,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count != SAT)) begin
      count_next = count + CNT_W'(1);
    end
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign terminal = (count == TERM);

endmodule

// File: rtl/sd_cmd_phys_engine.sv
// SD command engine: sequences load/send/response/busy/ack with the pad wrapper, retries timeouts.
// Outputs are registered decodes of the next state; host sees strobe_out and must return ack_in.
module sd_cmd_phys_engine
  import sd_cmd_pkg::*;
#(
  parameter int  RESP_WIDTH     = 136,
  parameter int  TIMEOUT_CYCLES = 64,
  parameter int  MAX_RETRIES    = 2,
  parameter int  STP_DELAY      = 1,
  localparam int RC_W           = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  strobe_in,
  input  logic                  ack_in,
  input  logic                  idle_in,
  input  logic [1:0]            resp_type_in,
  input  logic [RESP_WIDTH-1:0] pad_response,
  input  logic                  transmission_complete,
  input  logic                  reception_complete,
  input  logic                  busy_in,
  output logic                  strobe_out,
  output logic                  ack_out,
  output logic [RESP_WIDTH-1:0] response,
  output logic                  cmd_timeout,
  output logic [RC_W-1:0]       retry_count,
  output logic                  reset_wrapper,
  output logic                  pad_state,
  output logic                  pad_enable,
  output logic                  enable_pts_wrapper,
  output logic                  enable_stp_wrapper,
  output logic                  load_send
);

  localparam logic [RESP_WIDTH-1:0] SHORT_MASK =
    {{(RESP_WIDTH - SHORT_RESP_W){1'b0}}, {SHORT_RESP_W{1'b1}}};

  state_t           state, next_state;
  resp_type_t       resp_type_q;
  logic             capture, retry_now, timeout_now;
  logic             stay_waiting, retry_avail, stp_on;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_tc;

  assign retry_avail = (32'(retry_count) < 32'(MAX_RETRIES));

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    retry_now   = 1'b0;
    timeout_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe_in) next_state = ST_LOAD_COMMAND;
      end
      ST_LOAD_COMMAND: next_state = ST_SEND_COMMAND;
      ST_SEND_COMMAND: begin
        if (transmission_complete) begin
          next_state = (resp_type_q == RESP_NONE) ? ST_SEND_RESPONSE : ST_WAIT_RESPONSE;
        end
      end
      ST_WAIT_RESPONSE: begin
        // A response landing on the terminal cycle is still accepted.
        if (reception_complete) begin
          capture    = 1'b1;
          next_state = (resp_type_q == RESP_SHORT_BUSY) ? ST_WAIT_BUSY : ST_SEND_RESPONSE;
        end else if (cnt_tc) begin
          if (retry_avail) begin
            retry_now  = 1'b1;
            next_state = ST_LOAD_COMMAND;
          end else begin
            timeout_now = 1'b1;
            next_state  = ST_SEND_RESPONSE;
          end
        end
      end
      ST_WAIT_BUSY: begin
        if (!busy_in) begin
          next_state = ST_SEND_RESPONSE;
        end else if (cnt_tc) begin
          timeout_now = 1'b1;
          next_state  = ST_SEND_RESPONSE;
        end
      end
      ST_SEND_RESPONSE: next_state = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack_out) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (idle_in) begin
      next_state  = ST_IDLE;
      capture     = 1'b0;
      retry_now   = 1'b0;
      timeout_now = 1'b0;
    end
  end

  // Counter restarts on every entry into a waiting state, so busy wait reuses it cleanly.
  assign stay_waiting = (next_state == state) &&
                        ((state == ST_WAIT_RESPONSE) || (state == ST_WAIT_BUSY));

  sd_cmd_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .clear      (!stay_waiting),
    .enable     (stay_waiting),
    .count_next (cnt_next),
    .terminal   (cnt_tc)
  );

  assign stp_on = (next_state == ST_WAIT_RESPONSE) && (32'(cnt_next) >= 32'(STP_DELAY));

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      resp_type_q        <= RESP_NONE;
      retry_count        <= '0;
      cmd_timeout        <= 1'b0;
      response           <= '0;
      strobe_out         <= 1'b0;
      ack_out            <= 1'b0;
      reset_wrapper      <= 1'b1;
      pad_state          <= 1'b0;
      pad_enable         <= 1'b0;
      enable_pts_wrapper <= 1'b0;
      enable_stp_wrapper <= 1'b0;
      load_send          <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && strobe_in && !idle_in) begin
        resp_type_q <= resp_type_t'(resp_type_in);
      end

      if ((next_state == ST_IDLE) || (state == ST_IDLE)) begin
        retry_count <= '0;
      end else if (retry_now) begin
        retry_count <= retry_count + RC_W'(1);
      end

      if (next_state == ST_IDLE) begin
        cmd_timeout <= 1'b0;
      end else if (timeout_now) begin
        cmd_timeout <= 1'b1;
      end

      // Busy timeout keeps the captured response; a missing response reports zero.
      if (next_state == ST_IDLE) begin
        response <= '0;
      end else if (capture) begin
        response <= (resp_type_q == RESP_LONG) ? pad_response : (pad_response & SHORT_MASK);
      end else if (timeout_now && (state == ST_WAIT_RESPONSE)) begin
        response <= '0;
      end

      reset_wrapper      <= (next_state == ST_IDLE) || retry_now;
      pad_state          <= (next_state == ST_LOAD_COMMAND) || (next_state == ST_SEND_COMMAND);
      enable_pts_wrapper <= (next_state == ST_LOAD_COMMAND) || (next_state == ST_SEND_COMMAND);
      pad_enable         <= (next_state == ST_LOAD_COMMAND) || (next_state == ST_SEND_COMMAND) ||
                            (next_state == ST_WAIT_RESPONSE);
      load_send          <= (next_state == ST_SEND_COMMAND);
      enable_stp_wrapper <= stp_on;
      strobe_out         <= (next_state == ST_SEND_RESPONSE);
      ack_out            <= (state == ST_WAIT_ACK) && (next_state == ST_WAIT_ACK) && ack_in;
    end
  end

endmodule

// File: tb/tb_sd_cmd_phys_engine.sv
// Scenario bench for sd_cmd_phys_engine; a strobe monitor pops expected responses from a queue.
module tb_sd_cmd_phys_engine;

  localparam int RW = 136;
  localparam int TO = 64;
  localparam logic [RW-1:0] MASK48 = {{(RW - 48){1'b0}}, {48{1'b1}}};
  localparam logic [RW-1:0] PAT_A5 = {17{8'hA5}};
  localparam logic [RW-1:0] PAT_3C = {17{8'h3C}};
  localparam logic [RW-1:0] PAT_5A = {17{8'h5A}};

  logic          sd_clock, reset, strobe_in, ack_in, idle_in;
  logic [1:0]    resp_type_in;
  logic [RW-1:0] pad_response;
  logic          transmission_complete, reception_complete, busy_in;
  logic          strobe_out, ack_out, cmd_timeout;
  logic [RW-1:0] response;
  logic [1:0]    retry_count;
  logic          reset_wrapper, pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper, load_send;

  typedef struct packed {
    logic [RW-1:0] resp;
    logic          to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  sd_cmd_phys_engine #(
    .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2), .STP_DELAY(1)
  ) dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in), .idle_in(idle_in),
    .resp_type_in(resp_type_in), .pad_response(pad_response),
    .transmission_complete(transmission_complete), .reception_complete(reception_complete),
    .busy_in(busy_in), .strobe_out(strobe_out), .ack_out(ack_out), .response(response),
    .cmd_timeout(cmd_timeout), .retry_count(retry_count), .reset_wrapper(reset_wrapper),
    .pad_state(pad_state), .pad_enable(pad_enable), .enable_pts_wrapper(enable_pts_wrapper),
    .enable_stp_wrapper(enable_stp_wrapper), .load_send(load_send)
  );

  initial begin
    sd_clock = 1'b0;
    forever #5 sd_clock = ~sd_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge sd_clock) begin
    if (reset && strobe_out) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: response=%h cmd_timeout=%b, required no strobe", response, cmd_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (response !== mon_e.resp || cmd_timeout !== mon_e.to) begin
          errors++;
          $display("FAIL strobe_payload: response=%h cmd_timeout=%b, required response=%h cmd_timeout=%b",
                   response, cmd_timeout, mon_e.resp, mon_e.to);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sd_clock);
  endtask

  // Ends at the negedge where the engine sits in LOAD_COMMAND.
  task automatic issue(input logic [1:0] t);
    @(negedge sd_clock);
    strobe_in = 1'b1;
    resp_type_in = t;
    @(negedge sd_clock);
    strobe_in = 1'b0;
  endtask

  // From LOAD_COMMAND: completes transmission, ends at the first cycle after SEND_COMMAND.
  task automatic send_cmd();
    @(negedge sd_clock);
    transmission_complete = 1'b1;
    @(negedge sd_clock);
    transmission_complete = 1'b0;
  endtask

  // From the strobe cycle: acknowledges and ends back in IDLE.
  task automatic do_ack();
    @(negedge sd_clock);
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    @(negedge sd_clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobe_in = 0; ack_in = 0; idle_in = 0; resp_type_in = 2'd0; pad_response = '0;
    transmission_complete = 0; reception_complete = 0; busy_in = 0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if (reset_wrapper !== 1'b1) begin
      errors++; $display("FAIL reset_wrapper_in_reset: got %b required 1", reset_wrapper);
    end
    checks++;
    if ({strobe_out, ack_out, cmd_timeout, pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper, load_send} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b required 00000000",
        {strobe_out, ack_out, cmd_timeout, pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper, load_send});
    end
    checks++;
    if (response !== '0 || retry_count !== 2'd0) begin
      errors++; $display("FAIL reset_response: got %h/%0d required 0/0", response, retry_count);
    end
    tick(3);
    reset = 1'b1;
    tick(2);
    checks++;
    if (reset_wrapper !== 1'b1 || pad_enable !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: reset_wrapper=%b pad_enable=%b required 1/0", reset_wrapper, pad_enable);
    end
  endtask

  task automatic test_long();
    int s0;
    s0 = strobe_cnt;
    issue(2'd2);
    checks++;
    if ({pad_state, pad_enable, enable_pts_wrapper, load_send, reset_wrapper} !== 5'b11100) begin
      errors++; $display("FAIL load_outputs: got %b required 11100", {pad_state, pad_enable, enable_pts_wrapper, load_send, reset_wrapper});
    end
    @(negedge sd_clock);
    checks++;
    if ({pad_state, pad_enable, enable_pts_wrapper, load_send} !== 4'b1111) begin
      errors++; $display("FAIL send_outputs: got %b required 1111", {pad_state, pad_enable, enable_pts_wrapper, load_send});
    end
    transmission_complete = 1'b1;
    @(negedge sd_clock);
    transmission_complete = 1'b0;
    checks++;
    if ({pad_enable, pad_state, enable_stp_wrapper} !== 3'b100) begin
      errors++; $display("FAIL wait_first_cycle: got %b required 100", {pad_enable, pad_state, enable_stp_wrapper});
    end
    @(negedge sd_clock);
    checks++;
    if (enable_stp_wrapper !== 1'b1) begin
      errors++; $display("FAIL stp_enable: got %b required 1", enable_stp_wrapper);
    end
    tick(8);
    pad_response = PAT_A5;
    reception_complete = 1'b1;
    exp_q.push_back('{resp: PAT_A5, to: 1'b0});
    @(negedge sd_clock);
    reception_complete = 1'b0;
    checks++;
    if (strobe_out !== 1'b1) begin
      errors++; $display("FAIL long_strobe_latency: got %b required 1", strobe_out);
    end
    @(negedge sd_clock);
    checks++;
    if (strobe_out !== 1'b0 || response !== PAT_A5) begin
      errors++; $display("FAIL long_hold: strobe=%b response=%h required 0/%h", strobe_out, response, PAT_A5);
    end
    ack_in = 1'b1;
    @(negedge sd_clock);
    checks++;
    if (ack_out !== 1'b1) begin
      errors++; $display("FAIL ack_out: got %b required 1", ack_out);
    end
    ack_in = 1'b0;
    @(negedge sd_clock);
    checks++;
    if ({reset_wrapper, ack_out, strobe_out} !== 3'b100 || response !== '0) begin
      errors++; $display("FAIL back_to_idle: got %b response=%h required 100/0", {reset_wrapper, ack_out, strobe_out}, response);
    end
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++; $display("FAIL long_strobe_count: got %0d required 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_short();
    issue(2'd1);
    send_cmd();
    strobe_in = 1'b1;
    resp_type_in = 2'd0;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    tick(1);
    pad_response = '1;
    reception_complete = 1'b1;
    exp_q.push_back('{resp: MASK48, to: 1'b0});
    @(negedge sd_clock);
    reception_complete = 1'b0;
    checks++;
    if (strobe_out !== 1'b1 || response[47:0] !== 48'hFFFF_FFFF_FFFF || response[RW-1:48] !== '0) begin
      errors++; $display("FAIL short_mask: strobe=%b response=%h required 1/%h", strobe_out, response, MASK48);
    end
    do_ack();
    @(negedge sd_clock);
    checks++;
    if (pad_state !== 1'b0 || reset_wrapper !== 1'b1) begin
      errors++; $display("FAIL ignored_strobe: pad_state=%b reset_wrapper=%b required 0/1", pad_state, reset_wrapper);
    end
  endtask

  task automatic test_type0();
    exp_q.push_back('{resp: '0, to: 1'b0});
    issue(2'd0);
    send_cmd();
    checks++;
    if (strobe_out !== 1'b1 || pad_enable !== 1'b0) begin
      errors++; $display("FAIL no_response_type: strobe=%b pad_enable=%b required 1/0", strobe_out, pad_enable);
    end
    do_ack();
  endtask

  task automatic test_retry();
    int  k;
    int  pulses;
    bit  found;
    exp_q.push_back('{resp: '0, to: 1'b1});
    pad_response = PAT_3C;
    issue(2'd1);
    send_cmd();
    k = 0; pulses = 0; found = 1'b0;
    while (k < 400 && !found) begin
      if (strobe_out) begin
        found = 1'b1;
      end else begin
        if (reset_wrapper) pulses++;
        transmission_complete = load_send;
        @(negedge sd_clock);
        k++;
      end
    end
    transmission_complete = 1'b0;
    checks++;
    if (!found || k !== 3 * TO + 4) begin
      errors++; $display("FAIL retry_latency: found=%b cycles=%0d required 1/%0d", found, k, 3 * TO + 4);
    end
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL retry_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (retry_count !== 2'd2 || cmd_timeout !== 1'b1) begin
      errors++; $display("FAIL retry_count: got %0d/%b required 2/1", retry_count, cmd_timeout);
    end
    do_ack();
    checks++;
    if (retry_count !== 2'd0 || cmd_timeout !== 1'b0) begin
      errors++; $display("FAIL retry_clear: got %0d/%b required 0/0", retry_count, cmd_timeout);
    end
  endtask

  task automatic test_busy();
    int early;
    issue(2'd3);
    send_cmd();
    tick(2);
    pad_response = PAT_3C;
    reception_complete = 1'b1;
    busy_in = 1'b1;
    exp_q.push_back('{resp: PAT_3C & MASK48, to: 1'b0});
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sd_clock);
      reception_complete = 1'b0;
      if (strobe_out) early++;
    end
    busy_in = 1'b0;
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL busy_early_strobe: got %0d strobes required 0", early);
    end
    @(negedge sd_clock);
    checks++;
    if (strobe_out !== 1'b1 || cmd_timeout !== 1'b0) begin
      errors++; $display("FAIL busy_release: strobe=%b cmd_timeout=%b required 1/0", strobe_out, cmd_timeout);
    end
    do_ack();
  endtask

  task automatic test_race();
    issue(2'd2);
    send_cmd();
    tick(TO - 1);
    pad_response = PAT_5A;
    reception_complete = 1'b1;
    exp_q.push_back('{resp: PAT_5A, to: 1'b0});
    @(negedge sd_clock);
    reception_complete = 1'b0;
    checks++;
    if (strobe_out !== 1'b1 || retry_count !== 2'd0 || reset_wrapper !== 1'b0) begin
      errors++; $display("FAIL reception_vs_timeout: strobe=%b retry=%0d reset_wrapper=%b required 1/0/0",
                         strobe_out, retry_count, reset_wrapper);
    end
    do_ack();
  endtask

  task automatic test_idle_abort();
    int s0;
    issue(2'd2);
    send_cmd();
    tick(5);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    checks++;
    if ({reset_wrapper, pad_enable, enable_stp_wrapper, cmd_timeout} !== 4'b1000) begin
      errors++; $display("FAIL idle_abort: got %b required 1000", {reset_wrapper, pad_enable, enable_stp_wrapper, cmd_timeout});
    end
    s0 = strobe_cnt;
    tick(TO + 16);
    checks++;
    if (strobe_cnt - s0 !== 0 || pad_enable !== 1'b0) begin
      errors++; $display("FAIL idle_abort_quiet: strobes=%0d pad_enable=%b required 0/0", strobe_cnt - s0, pad_enable);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    issue(2'd2);
    @(negedge sd_clock);
    checks++;
    if (load_send !== 1'b1) begin
      errors++; $display("FAIL reach_send: load_send=%b required 1", load_send);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (load_send !== 1'b0 || reset_wrapper !== 1'b1 || pad_state !== 1'b0) begin
      errors++; $display("FAIL async_reset: load_send=%b reset_wrapper=%b pad_state=%b required 0/1/0",
                         load_send, reset_wrapper, pad_state);
    end
    @(negedge sd_clock);
    reset = 1'b1;
    s0 = strobe_cnt;
    tick(20);
    checks++;
    if (strobe_cnt - s0 !== 0 || pad_enable !== 1'b0) begin
      errors++; $display("FAIL reset_abort_quiet: strobes=%0d pad_enable=%b required 0/0", strobe_cnt - s0, pad_enable);
    end
  endtask

  initial begin
    test_reset();
    test_long();
    test_short();
    test_type0();
    test_retry();
    test_busy();
    test_race();
    test_idle_abort();
    test_reset_mid();
    tick(2);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
